// File: rtl/dtfag_r16_lane_loader_if.sv
// Bus of the DTFAG radix-16 lane loader: serial word stream in, sixteen-lane
// group out with the multiplier-select code and group index.
// master: word source + group consumer side.  slave: the loader itself.
interface dtfag_r16_lane_loader_if #(
    parameter int D_WIDTH = 64,
    parameter int GRP_W   = 12
);
    // serial word stream
    logic [D_WIDTH-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic               flush;

    // parallel group presented to the multiplier-select mux
    logic [D_WIDTH-1:0] R16_out0;
    logic [D_WIDTH-1:0] R16_out1;
    logic [D_WIDTH-1:0] R16_out2;
    logic [D_WIDTH-1:0] R16_out3;
    logic [D_WIDTH-1:0] R16_out4;
    logic [D_WIDTH-1:0] R16_out5;
    logic [D_WIDTH-1:0] R16_out6;
    logic [D_WIDTH-1:0] R16_out7;
    logic [D_WIDTH-1:0] R16_out8;
    logic [D_WIDTH-1:0] R16_out9;
    logic [D_WIDTH-1:0] R16_out10;
    logic [D_WIDTH-1:0] R16_out11;
    logic [D_WIDTH-1:0] R16_out12;
    logic [D_WIDTH-1:0] R16_out13;
    logic [D_WIDTH-1:0] R16_out14;
    logic [D_WIDTH-1:0] R16_out15;
    logic [1:0]         Mul_sel;
    logic               grp_valid;
    logic               grp_ready;
    logic [GRP_W-1:0]   grp_cnt;

    modport master (
        output in_data, in_valid, flush, grp_ready,
        input  in_ready,
        input  R16_out0, R16_out1, R16_out2, R16_out3,
        input  R16_out4, R16_out5, R16_out6, R16_out7,
        input  R16_out8, R16_out9, R16_out10, R16_out11,
        input  R16_out12, R16_out13, R16_out14, R16_out15,
        input  Mul_sel, grp_valid, grp_cnt
    );

    modport slave (
        input  in_data, in_valid, flush, grp_ready,
        output in_ready,
        output R16_out0, R16_out1, R16_out2, R16_out3,
        output R16_out4, R16_out5, R16_out6, R16_out7,
        output R16_out8, R16_out9, R16_out10, R16_out11,
        output R16_out12, R16_out13, R16_out14, R16_out15,
        output Mul_sel, grp_valid, grp_cnt
    );
endinterface

// File: rtl/dtfag_r16_lane_loader.sv
// Serial-to-parallel radix-16 lane loader for the DTFAG multiplier front end.
// Words are collected into a fill bank; a completed group (16 words, or fewer
// closed by flush and zero-padded) is copied into the registered presentation
// bank that drives R16_out0..15 with Mul_sel = 2'd1.
//
// Build option: define DTFAG_LDR_PINGPONG_EN to let the fill bank keep
// accepting while a group is presented (two groups in flight); without it a
// single group is held and input stalls while it is presented.
module dtfag_r16_lane_loader #(
    parameter int D_WIDTH = 64,
    parameter int GRP_W   = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    dtfag_r16_lane_loader_if.slave bus
);
    localparam int               LANES   = 16;
    localparam logic [GRP_W-1:0] GRP_ONE = {{(GRP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        FILL_EMPTY   = 2'd0,
        FILL_FILLING = 2'd1,
        FILL_FULL    = 2'd2
    } fill_state_e;

    fill_state_e        fill_state_q;
    fill_state_e        fill_state_d;
    logic [3:0]         lane_cnt_q;
    logic [3:0]         lane_cnt_d;
    logic [D_WIDTH-1:0] fill_q   [LANES];
    logic [D_WIDTH-1:0] out_q    [LANES];
    logic [D_WIDTH-1:0] out_d    [LANES];
    logic [D_WIDTH-1:0] merged_s [LANES];
    logic               grp_valid_q;
    logic               grp_valid_d;
    logic [1:0]         mul_sel_q;
    logic [1:0]         mul_sel_d;
    logic [GRP_W-1:0]   grp_cnt_q;
    logic [GRP_W-1:0]   grp_cnt_d;
    logic               in_ready_q;
    logic               in_ready_d;

    logic               in_xfer_s;
    logic               grp_xfer_s;
    logic               out_free_s;
    logic [4:0]         eff_cnt_s;
    logic               do_pad_s;
    logic               complete_s;
    logic               load_from_fill_s;
    logic               load_from_merged_s;

    // Handshakes: in_ready is a register, so transfers never loop through it.
    assign in_xfer_s  = bus.in_valid && in_ready_q;
    assign grp_xfer_s = grp_valid_q && bus.grp_ready;
    // The presentation bank can take a new group if empty or being taken now.
    assign out_free_s = !grp_valid_q || grp_xfer_s;

    // Number of lanes occupied once this cycle's word (if any) is written.
    assign eff_cnt_s  = {1'b0, lane_cnt_q} + {4'd0, in_xfer_s};
    // Flush closes a non-empty partial group; a group completed by the 16th
    // word needs no padding, and an empty group ignores flush.
    assign do_pad_s   = bus.flush && (fill_state_q != FILL_FULL)
                        && (eff_cnt_s != 5'd0) && (eff_cnt_s != 5'd16);
    assign complete_s = (in_xfer_s && (lane_cnt_q == 4'd15)) || do_pad_s;

    // Fill bank view after this cycle: incoming word first, then zero padding.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            if (in_xfer_s && (lane_cnt_q == 4'(k))) begin
                merged_s[k] = bus.in_data;
            end else if (do_pad_s && (5'(k) >= eff_cnt_s)) begin
                merged_s[k] = {D_WIDTH{1'b0}};
            end else begin
                merged_s[k] = fill_q[k];
            end
        end
    end

    // Fill-bank state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_state_q <= FILL_EMPTY;
        end else begin
            fill_state_q <= fill_state_d;
        end
    end

    // Fill-bank next state: a completed group either moves straight into the
    // presentation bank (back to EMPTY) or waits there as FULL.
    always_comb begin
        fill_state_d = fill_state_q;
        case (fill_state_q)
            FILL_EMPTY, FILL_FILLING: begin
                if (complete_s) begin
                    fill_state_d = out_free_s ? FILL_EMPTY : FILL_FULL;
                end else if (in_xfer_s) begin
                    fill_state_d = FILL_FILLING;
                end else begin
                    fill_state_d = fill_state_q;
                end
            end
            FILL_FULL: begin
                if (out_free_s) begin
                    fill_state_d = FILL_EMPTY;
                end else begin
                    fill_state_d = FILL_FULL;
                end
            end
            default: begin
                fill_state_d = FILL_EMPTY;
            end
        endcase
    end

    // Fill-bank outputs: which source loads the presentation bank this cycle.
    always_comb begin
        load_from_fill_s   = 1'b0;
        load_from_merged_s = 1'b0;
        case (fill_state_q)
            FILL_EMPTY, FILL_FILLING: begin
                load_from_merged_s = complete_s && out_free_s;
            end
            FILL_FULL: begin
                load_from_fill_s = out_free_s;
            end
            default: begin
                load_from_fill_s   = 1'b0;
                load_from_merged_s = 1'b0;
            end
        endcase
    end

    // Next lane counter, presentation bank, group flags and group index.
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        if (complete_s) begin
            lane_cnt_d = 4'd0;
        end else if (in_xfer_s) begin
            lane_cnt_d = lane_cnt_q + 4'd1;
        end else begin
            lane_cnt_d = lane_cnt_q;
        end

        grp_valid_d = grp_valid_q;
        if (load_from_fill_s || load_from_merged_s) begin
            grp_valid_d = 1'b1;
        end else if (grp_xfer_s) begin
            grp_valid_d = 1'b0;
        end else begin
            grp_valid_d = grp_valid_q;
        end

        // Lanes read as zero whenever no group is presented.
        for (int k = 0; k < LANES; k++) begin
            out_d[k] = out_q[k];
            if (load_from_fill_s) begin
                out_d[k] = fill_q[k];
            end else if (load_from_merged_s) begin
                out_d[k] = merged_s[k];
            end else if (grp_xfer_s) begin
                out_d[k] = {D_WIDTH{1'b0}};
            end else begin
                out_d[k] = out_q[k];
            end
        end

        mul_sel_d = grp_valid_d ? 2'd1 : 2'd0;
        grp_cnt_d = grp_xfer_s ? (grp_cnt_q + GRP_ONE) : grp_cnt_q;

`ifdef DTFAG_LDR_PINGPONG_EN
        // Stall only when a group is presented and another one waits.
        in_ready_d = (fill_state_d != FILL_FULL);
`else
        // Single group in flight: stall while it is presented.
        in_ready_d = !(grp_valid_d || (fill_state_d == FILL_FULL));
`endif
    end

    // Datapath registers; reset discards any partial or presented group.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt_q  <= 4'd0;
            grp_valid_q <= 1'b0;
            mul_sel_q   <= 2'd0;
            grp_cnt_q   <= {GRP_W{1'b0}};
            in_ready_q  <= 1'b1;
            for (int k = 0; k < LANES; k++) begin
                fill_q[k] <= {D_WIDTH{1'b0}};
                out_q[k]  <= {D_WIDTH{1'b0}};
            end
        end else begin
            lane_cnt_q  <= lane_cnt_d;
            grp_valid_q <= grp_valid_d;
            mul_sel_q   <= mul_sel_d;
            grp_cnt_q   <= grp_cnt_d;
            in_ready_q  <= in_ready_d;
            for (int k = 0; k < LANES; k++) begin
                fill_q[k] <= merged_s[k];
                out_q[k]  <= out_d[k];
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.grp_valid = grp_valid_q;
    assign bus.Mul_sel   = mul_sel_q;
    assign bus.grp_cnt   = grp_cnt_q;
    assign bus.R16_out0  = out_q[0];
    assign bus.R16_out1  = out_q[1];
    assign bus.R16_out2  = out_q[2];
    assign bus.R16_out3  = out_q[3];
    assign bus.R16_out4  = out_q[4];
    assign bus.R16_out5  = out_q[5];
    assign bus.R16_out6  = out_q[6];
    assign bus.R16_out7  = out_q[7];
    assign bus.R16_out8  = out_q[8];
    assign bus.R16_out9  = out_q[9];
    assign bus.R16_out10 = out_q[10];
    assign bus.R16_out11 = out_q[11];
    assign bus.R16_out12 = out_q[12];
    assign bus.R16_out13 = out_q[13];
    assign bus.R16_out14 = out_q[14];
    assign bus.R16_out15 = out_q[15];
endmodule

// File: tb/tb_dtfag_r16_lane_loader.sv
// Self-checking bench for dtfag_r16_lane_loader.  Reference model: a queue of
// accepted words grouped by 16 (or by flush, zero-padded) into a queue of
// complete groups; the loader holds at most CAP groups and presents the oldest.
module tb_dtfag_r16_lane_loader;
    localparam int D_WIDTH = 64;
    localparam int GRP_W   = 12;
    localparam int GRP_N   = 1 << GRP_W;
`ifdef DTFAG_LDR_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef logic [15:0][63:0] grp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] partial[$];
    grp_t        expq[$];
    int          m_cnt  = 0;
    int          m_pops = 0;

    dtfag_r16_lane_loader_if #(.D_WIDTH(D_WIDTH), .GRP_W(GRP_W)) bus ();

    dtfag_r16_lane_loader #(.D_WIDTH(D_WIDTH), .GRP_W(GRP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [63:0] lanes [16];
    assign lanes[0]  = bus.R16_out0;
    assign lanes[1]  = bus.R16_out1;
    assign lanes[2]  = bus.R16_out2;
    assign lanes[3]  = bus.R16_out3;
    assign lanes[4]  = bus.R16_out4;
    assign lanes[5]  = bus.R16_out5;
    assign lanes[6]  = bus.R16_out6;
    assign lanes[7]  = bus.R16_out7;
    assign lanes[8]  = bus.R16_out8;
    assign lanes[9]  = bus.R16_out9;
    assign lanes[10] = bus.R16_out10;
    assign lanes[11] = bus.R16_out11;
    assign lanes[12] = bus.R16_out12;
    assign lanes[13] = bus.R16_out13;
    assign lanes[14] = bus.R16_out14;
    assign lanes[15] = bus.R16_out15;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: drive inputs, advance the model at posedge, return at negedge.
    task automatic step(input logic v, input logic [63:0] d, input logic fl, input logic gr);
        logic ix;
        logic gx;
        grp_t g;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = fl;
        bus.grp_ready = gr;
        ix = v && (expq.size() < CAP);
        gx = gr && (expq.size() != 0);
        @(posedge clk);
        if (gx) begin
            g = expq.pop_front();
            m_cnt  = (m_cnt + 1) % GRP_N;
            m_pops = m_pops + 1;
        end
        if (ix) partial.push_back(d);
        if ((partial.size() == 16) || (fl && (partial.size() != 0))) begin
            g = '0;
            foreach (partial[i]) g[i] = partial[i];
            expq.push_back(g);
            partial.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.flush = 1'b0; bus.grp_ready = 1'b0;
        @(posedge clk);
        expq.delete(); partial.delete(); m_cnt = 0; m_pops = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.grp_valid !== 1'b0) begin errors++; $display("FAIL reset_grp_valid got %b exp 0", bus.grp_valid); end
        checks++; if (bus.Mul_sel !== 2'd0) begin errors++; $display("FAIL reset_mul_sel got %0d exp 0", bus.Mul_sel); end
        checks++; if (bus.grp_cnt !== 12'd0) begin errors++; $display("FAIL reset_grp_cnt got %0d exp 0", bus.grp_cnt); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (lanes[k] !== 64'd0) begin errors++; $display("FAIL reset_lane%0d got %h exp 0", k, lanes[k]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 64'(i), 1'b0, 1'b1);
            if (i == 15) begin
                checks++; if (bus.grp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", bus.grp_valid); end
            end
        end
        checks++; if (bus.grp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", bus.grp_valid); end
        checks++; if (bus.Mul_sel !== 2'd1) begin errors++; $display("FAIL basic_mul_sel got %0d exp 1", bus.Mul_sel); end
        checks++; if (bus.grp_cnt !== 12'd0) begin errors++; $display("FAIL basic_grp_cnt got %0d exp 0", bus.grp_cnt); end
        checks++; if (bus.in_ready !== (CAP == 2)) begin errors++; $display("FAIL basic_in_ready got %b exp %b", bus.in_ready, (CAP == 2)); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (lanes[k] !== 64'(k + 1)) begin errors++; $display("FAIL basic_lane%0d got %h exp %h", k, lanes[k], 64'(k + 1)); end
        end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        checks++; if (bus.grp_valid !== 1'b0) begin errors++; $display("FAIL basic_after_valid got %b exp 0", bus.grp_valid); end
        checks++; if (bus.Mul_sel !== 2'd0) begin errors++; $display("FAIL basic_after_mul_sel got %0d exp 0", bus.Mul_sel); end
        checks++; if (bus.grp_cnt !== 12'd1) begin errors++; $display("FAIL basic_after_grp_cnt got %0d exp 1", bus.grp_cnt); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (lanes[k] !== 64'd0) begin errors++; $display("FAIL basic_after_lane%0d got %h exp 0", k, lanes[k]); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] w [16];
        logic [63:0] nxt;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            w[i] = {$urandom, $urandom};
            step(1'b1, w[i], 1'b0, 1'b0);
        end
        step(1'b0, 64'd0, 1'b1, 1'b0);
        checks++; if (bus.grp_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", bus.grp_valid); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (lanes[k] !== ((k < 5) ? w[k] : 64'd0)) begin
                errors++; $display("FAIL flush_lane%0d got %h exp %h", k, lanes[k], ((k < 5) ? w[k] : 64'd0));
            end
        end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        nxt = {$urandom, $urandom};
        step(1'b1, nxt, 1'b0, 1'b0);
        for (int i = 1; i < 16; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        checks++; if (bus.grp_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %b exp 1", bus.grp_valid); end
        checks++; if (lanes[0] !== nxt) begin errors++; $display("FAIL flush_next_lane0 got %h exp %h", lanes[0], nxt); end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        // flush with nothing collected must not create a group
        step(1'b0, 64'd0, 1'b1, 1'b1);
        checks++; if (bus.grp_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid got %b exp 0", bus.grp_valid); end
        // flush together with the 16th word: full group, no padding group after
        for (int i = 0; i < 16; i++) begin
            w[i] = {$urandom, $urandom};
            step(1'b1, w[i], (i == 15), 1'b0);
        end
        checks++; if (lanes[15] !== w[15]) begin errors++; $display("FAIL flush16_lane15 got %h exp %h", lanes[15], w[15]); end
        checks++; if (lanes[0] !== w[0]) begin errors++; $display("FAIL flush16_lane0 got %h exp %h", lanes[0], w[0]); end
        step(1'b0, 64'd0, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b0, 1'b1);
        checks++; if (bus.grp_valid !== 1'b0) begin errors++; $display("FAIL flush16_extra_valid got %b exp 0", bus.grp_valid); end
    endtask

    task automatic test_backpressure();
        int   accepted;
        int   drop_at;
        logic [63:0] first;
        grp_t eg;
        do_reset();
        accepted = 0; drop_at = -1;
        first = {$urandom, $urandom};
        for (int c = 0; c < 40; c++) begin
            if (bus.in_ready === 1'b1) accepted++;
            else if (drop_at < 0) drop_at = accepted;
            step(1'b1, (c == 0) ? first : {$urandom, $urandom}, 1'b0, 1'b0);
            checks++; if (bus.in_ready !== (expq.size() < CAP)) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b exp %b", c, bus.in_ready, (expq.size() < CAP)); end
            if (bus.grp_valid === 1'b1) begin
                checks++; if (bus.grp_cnt !== 12'd0 || lanes[0] !== first) begin errors++; $display("FAIL bp_hold cyc %0d cnt %0d lane0 %h exp 0 %h", c, bus.grp_cnt, lanes[0], first); end
            end
        end
        checks++; if (drop_at != CAP * 16) begin errors++; $display("FAIL bp_drop_point got %0d exp %0d", drop_at, CAP * 16); end
        for (int c = 0; c < 40; c++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1);
            eg = (expq.size() != 0) ? expq[0] : '0;
            checks++; if (bus.grp_valid !== (expq.size() != 0)) begin errors++; $display("FAIL bp_drain_valid got %b exp %b", bus.grp_valid, (expq.size() != 0)); end
            for (int k = 0; k < 16; k++) begin
                checks++; if (lanes[k] !== eg[k]) begin errors++; $display("FAIL bp_drain_lane%0d got %h exp %h", k, lanes[k], eg[k]); end
            end
        end
        checks++; if (bus.grp_cnt !== 12'(CAP)) begin errors++; $display("FAIL bp_groups_out got %0d exp %0d", bus.grp_cnt, CAP); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] w [16];
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
        do_reset();
        checks++; if (bus.in_ready !== 1'b1 || bus.grp_valid !== 1'b0 || bus.Mul_sel !== 2'd0 || bus.grp_cnt !== 12'd0) begin
            errors++; $display("FAIL rstmid_ctrl got rdy %b vld %b sel %0d cnt %0d exp 1 0 0 0", bus.in_ready, bus.grp_valid, bus.Mul_sel, bus.grp_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            w[i] = {$urandom, $urandom};
            step(1'b1, w[i], 1'b0, 1'b0);
        end
        checks++; if (bus.grp_valid !== 1'b1 || bus.grp_cnt !== 12'd0) begin errors++; $display("FAIL rstmid_grp got vld %b cnt %0d exp 1 0", bus.grp_valid, bus.grp_cnt); end
        for (int k = 0; k < 16; k++) begin
            checks++; if (lanes[k] !== w[k]) begin errors++; $display("FAIL rstmid_lane%0d got %h exp %h", k, lanes[k], w[k]); end
        end
        step(1'b0, 64'd0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        grp_t eg;
        logic ev;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 9) < 7), {$urandom, $urandom}, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
            ev = (expq.size() != 0);
            eg = ev ? expq[0] : '0;
            checks++; if (bus.in_ready !== (expq.size() < CAP)) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b exp %b", c, bus.in_ready, (expq.size() < CAP)); end
            checks++; if (bus.grp_valid !== ev) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, bus.grp_valid, ev); end
            checks++; if (bus.Mul_sel !== (ev ? 2'd1 : 2'd0)) begin errors++; $display("FAIL rnd_mul_sel cyc %0d got %0d exp %0d", c, bus.Mul_sel, ev); end
            checks++; if (bus.grp_cnt !== 12'(m_cnt)) begin errors++; $display("FAIL rnd_grp_cnt cyc %0d got %0d exp %0d", c, bus.grp_cnt, m_cnt); end
            for (int k = 0; k < 16; k++) begin
                checks++; if (lanes[k] !== eg[k]) begin errors++; $display("FAIL rnd_lane%0d cyc %0d got %h exp %h", k, c, lanes[k], eg[k]); end
            end
        end
    endtask

    task automatic test_wrap();
        bit         saw_top;
        bit         got_last;
        logic [11:0] last_cnt;
        do_reset();
        saw_top = 1'b0; got_last = 1'b0; last_cnt = 12'hfff;
        for (int c = 0; (c < 12000) && (m_pops < 4097); c++) begin
            step(1'b1, {$urandom, $urandom}, 1'b1, 1'b1);
            if (expq.size() != 0) begin
                checks++; if (bus.grp_cnt !== 12'(m_cnt)) begin errors++; $display("FAIL wrap_grp_cnt got %0d exp %0d", bus.grp_cnt, m_cnt); end
                checks++; if (lanes[0] !== expq[0][0] || lanes[1] !== 64'd0) begin errors++; $display("FAIL wrap_lanes got %h %h exp %h 0", lanes[0], lanes[1], expq[0][0]); end
                if (bus.grp_cnt === 12'd4095) saw_top = 1'b1;
                if (m_pops == 4096) begin got_last = 1'b1; last_cnt = bus.grp_cnt; end
            end
        end
        checks++; if (m_pops != 4097) begin errors++; $display("FAIL wrap_budget got %0d groups exp 4097", m_pops); end
        checks++; if (!saw_top) begin errors++; $display("FAIL wrap_top got never exp 4095 seen"); end
        checks++; if (!got_last || last_cnt !== 12'd0) begin errors++; $display("FAIL wrap_last got %0d exp 0", last_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.flush = 1'b0; bus.grp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_basic();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dtfag_r16_lane_loader.md
# dtfag_r16_lane_loader

Serial-to-parallel lane loader that builds radix-16 operand groups for the DTFAG multiplier front end. It accepts one D_WIDTH word per cycle over a valid/ready stream and assembles 16 consecutive words into a lane bank. It then presents the bank on sixteen parallel lanes with `Mul_sel` = 2'd1, so the downstream multiplier-select mux passes the lanes through. It is the producing end of the `R16_in0..15` / `Mul_sel` interface and sits between the twiddle/data stream source and that mux.

## Interface
- `D_WIDTH`, 64: lane data width; matches `` `D_width ``.
- `GRP_W`, 12: group counter width (65536/16 = 4096 groups).
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_data` input D_WIDTH: serial word.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader can accept a word this cycle.
- `flush` input 1: close the partial group now and zero-pad it.
- `R16_out0` … `R16_out15` output D_WIDTH each: lane k carries the k-th accepted word of the group.
- `Mul_sel` output 2: 2'd1 when a group is presented, else 2'd0.
- `grp_valid` output 1: a complete group is on the lanes.
- `grp_ready` input 1: consumer takes the group.
- `grp_cnt` output GRP_W: index of the presented group; wraps modulo 2^GRP_W.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `grp_valid && grp_ready`.
- Filling:
  - A 4-bit `lane_cnt` selects the lane written by each input transfer and increments on every transfer.
  - On the transfer with `lane_cnt`=15, the write buffer becomes FULL and `lane_cnt` wraps to 0.
- Per-buffer states: EMPTY, FILLING, FULL.
  - EMPTY→FILLING on the first transfer.
  - FILLING→FULL on the 16th transfer or on `flush`.
  - FULL→EMPTY on the output transfer.
- Flush:
  - `flush` with `lane_cnt`>0 zero-fills lanes `lane_cnt`..15 and marks the buffer FULL.
  - `flush` with `lane_cnt`=0 is ignored.
  - If `flush` and an input transfer occur in the same cycle, the word is written first, then the remaining lanes are padded. If that word was lane 15, no padding is needed.
- Output lanes:
  - The `R16_out*` lanes show the read buffer contents.
  - All lanes and `Mul_sel` are 0 whenever `grp_valid`=0.
  - `Mul_sel` = `grp_valid` ? 2'd1 : 2'd0. The value 2'd2 is never driven.
- Group counter: `grp_cnt` increments on each output transfer and wraps to 0 after 2^GRP_W−1.
- Ordering: groups leave in arrival order. No group is dropped or duplicated.
- Reset: `rst` clears every buffer to EMPTY and zeroes `lane_cnt`, `grp_cnt`, and all lane registers. Reset mid-group discards the partial group.

## Timing
- Reset values: `in_ready`=1, `grp_valid`=0, `Mul_sel`=0, `R16_out*`=0, `grp_cnt`=0.
- Latency: if the 16th word is accepted in cycle t, `grp_valid`=1 and the lanes are valid in cycle t+1. A flush has the same latency.
- `grp_valid`, the lanes, and `Mul_sel` are registered. They hold stable until the output transfer.
- `in_ready` depends only on registered state, never combinationally on `in_valid` or `grp_ready`.
- When a group completes in the same cycle as an output transfer, both take effect. There is no bubble when the other buffer is FULL.
- Sustained throughput with ping-pong enabled and `grp_ready` held high: 16 words in, 1 group out every 16 cycles, with no `in_ready` deassertion.

## Configuration
- `DTFAG_LDR_PINGPONG_EN` defined: two lane buffers.
  - One buffer fills while the other is presented.
  - `in_ready`=0 only when both buffers are FULL.
- `DTFAG_LDR_PINGPONG_EN` undefined: one buffer.
  - `in_ready`=0 from the cycle after the buffer becomes FULL until the cycle after its output transfer.
  - Peak throughput is 1 group per 17 cycles.

## Test plan
- Reset, then 16 words 0x1..0x10 with `grp_ready`=1 → `grp_valid` rises in cycle 17, `R16_out0`=0x1, `R16_out15`=0x10, `Mul_sel`=2'd1, and `grp_cnt`=0 for one cycle, then 0 lanes and `Mul_sel`=0.
- 5 words then `flush` → `R16_out0..4` = the words, `R16_out5..15`=0. The next group's lane 0 is the following word.
- Continuous input, `grp_ready` low for 40 cycles:
  - with `DTFAG_LDR_PINGPONG_EN`, `in_ready` drops after word 32 and group 0 is held;
  - without it, `in_ready` drops after word 16;
  - in both cases no data is lost after `grp_ready` is released.
- `rst` asserted after 9 words of a group → all outputs are at reset values next cycle; the subsequent 16 words form group 0 with no residue.
- 4097 groups streamed → `grp_cnt` reaches 4095, then the last group shows 0 (wrap).
